mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single memory port between two masters: port 0 (CPU fetch/load/store)
//   and port 1 (DMA/debug loader). Round-robin arbitration, one transaction in flight.
//   Latches the winning request, drives memory for MEM_LATENCY cycles, returns read
//   data with a one-cycle ack pulse. Sits between the CPU and memory in the MCU top.
// PARAMETERS
//   ADDR_W       32  address width
//   DATA_W       32  data width
//   MEM_LATENCY  1   cycles mem_read/mem_write held before mem_data_in is sampled (>=1)
// PORTS
//   clk            in   1       clock, rising edge
//   n_reset        in   1       asynchronous, active-low reset
//   m0_req         in   1       port 0 request; hold until m0_ack
//   m0_we          in   1       port 0: 1=write, 0=read
//   m0_addr        in   ADDR_W  port 0 address
//   m0_wdata       in   DATA_W  port 0 write data
//   m0_rdata       out  DATA_W  port 0 read data, valid while m0_ack=1
//   m0_ack         out  1       port 0 completion, 1-cycle pulse
//   m1_req/m1_we/m1_addr/m1_wdata/m1_rdata/m1_ack  same as port 0, for port 1
//   mem_address    out  ADDR_W  to memory
//   mem_data_out   out  DATA_W  write data to memory
//   mem_data_in    in   DATA_W  read data from memory
//   mem_read       out  1       memory read strobe
//   mem_write      out  1       memory write strobe
//   bus_owner      out  1       port holding the bus (0/1); meaningful when busy=1
//   busy           out  1       1 in ACCESS or RESP
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie.
//   Outputs are registered; no combinational path from inputs to outputs.
//   FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   - IDLE: at an edge where any req=1, pick the winner and latch we/addr/wdata.
//     Update last_grant, load cnt=MEM_LATENCY-1, assert mem_read or mem_write,
//     go to ACCESS.
//   - Arbitration: only one req -> that port. Both -> port != last_grant.
//   - ACCESS: mem_address/mem_data_out/strobe stay constant from the latched values.
//     mem_data_out=wdata on writes, 0 on reads. Decrement cnt each edge. At the edge
//     where cnt==0: capture mem_data_in (reads only), drop the strobes, set the
//     owner's ack=1, go to RESP.
//   - RESP: ack high for exactly this cycle. Owner's rdata = captured data (reads);
//     unchanged on writes. At the next edge: ack=0, go to IDLE.
//   - Non-owner rdata/ack are never touched.
//   Latency: req sampled at edge k -> strobe high cycles k..k+MEM_LATENCY ->
//     ack high in the cycle after edge k+MEM_LATENCY. Back-to-back throughput is one
//     transaction per MEM_LATENCY+2 cycles (IDLE costs a cycle).
//   Requests arriving in ACCESS/RESP are not sampled; they wait for IDLE.
//   After ack the master may keep req=1: that is a new transaction, arbitrated at
//     the next IDLE edge.
//   req dropped mid-transaction: ignored; the transaction completes and acks.
//   Attributes changed after grant: ignored (latched copies used).
//   Never mem_read and mem_write together; both 0 outside ACCESS.
//   n_reset mid-transaction: immediate abort, outputs to 0, last_grant=1, no ack.
// TESTING
//   1 Reset, MEM_LATENCY=1. m0 read 0x100, memory returns 0xE3A01005 -> mem_read high
//     1 cycle, addr 0x100; m0_ack the next cycle with m0_rdata=0xE3A01005.
//   2 m1 write addr 0x200 data 0xDEADBEEF -> mem_write=1, mem_data_out=0xDEADBEEF,
//     m1_ack pulse; m0_ack stays 0; m1_rdata unchanged.
//   3 m0,m1 both held high, 4 transactions -> grants 0,1,0,1; each ack exactly 1
//     cycle; IDLE cycle between transactions.
//   4 MEM_LATENCY=3: read 0x40 -> strobe high 3 cycles; data sampled on the 3rd edge;
//     change mem_data_in to 0x0 after that edge -> rdata keeps the sampled value.
//   5 m0 changes addr 0x100->0x104 and drops req during ACCESS -> mem_address stays
//     0x100; ack still pulses.
//   6 n_reset low during ACCESS -> strobes/acks 0 at once; after release, m0+m1 tie
//     -> port 0 granted.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle shared by the two bus masters, the arbiter and the single memory port.
// The arbiter takes the slave view; the masters/memory side (or a bench) takes the master view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_read;
    logic              mem_write;

    logic              bus_owner;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_rdata, m1_ack,
        output mem_address, mem_data_out, mem_read, mem_write,
        input  mem_data_in,
        output bus_owner, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack,
        input  mem_address, mem_data_out, mem_read, mem_write,
        output mem_data_in,
        input  bus_owner, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the single memory port: one transaction in flight,
// memory strobes held MEM_LATENCY cycles, read data returned with a one-cycle ack.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q,      state_d;
    logic              lastGrant_q,  lastGrant_d;
    logic              owner_q,      owner_d;
    logic              we_q,         we_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] memAddr_q,    memAddr_d;
    logic [DATA_W-1:0] memDataOut_q, memDataOut_d;
    logic              memRead_q,    memRead_d;
    logic              memWrite_q,   memWrite_d;
    logic [DATA_W-1:0] m0Rdata_q,    m0Rdata_d;
    logic              m0Ack_q,      m0Ack_d;
    logic [DATA_W-1:0] m1Rdata_q,    m1Rdata_d;
    logic              m1Ack_q,      m1Ack_d;

    logic              anyReq;
    logic              grant;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        anyReq = bus.m0_req | bus.m1_req;
        grant  = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            grant = ~lastGrant_q;
        end else begin
            grant = bus.m1_req;
        end
        selWe    = grant ? bus.m1_we    : bus.m0_we;
        selAddr  = grant ? bus.m1_addr  : bus.m0_addr;
        selWdata = grant ? bus.m1_wdata : bus.m0_wdata;
    end

    always_comb begin
        state_d      = state_q;
        lastGrant_d  = lastGrant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        memAddr_d    = memAddr_q;
        memDataOut_d = memDataOut_q;
        memRead_d    = memRead_q;
        memWrite_d   = memWrite_q;
        m0Rdata_d    = m0Rdata_q;
        m1Rdata_d    = m1Rdata_q;
        m0Ack_d      = 1'b0;
        m1Ack_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (anyReq) begin
                    owner_d      = grant;
                    lastGrant_d  = grant;
                    we_d         = selWe;
                    cnt_d        = CNT_LOAD;
                    memAddr_d    = selAddr;
                    memDataOut_d = selWe ? selWdata : '0;
                    memRead_d    = ~selWe;
                    memWrite_d   = selWe;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                    if (owner_q) begin
                        m1Ack_d = 1'b1;
                        if (!we_q) begin
                            m1Rdata_d = bus.mem_data_in;
                        end
                    end else begin
                        m0Ack_d = 1'b1;
                        if (!we_q) begin
                            m0Rdata_d = bus.mem_data_in;
                        end
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset aborts any transaction outright; last grant returns to port 1 so port 0 wins the next tie.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            lastGrant_q  <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            memAddr_q    <= '0;
            memDataOut_q <= '0;
            memRead_q    <= 1'b0;
            memWrite_q   <= 1'b0;
            m0Rdata_q    <= '0;
            m0Ack_q      <= 1'b0;
            m1Rdata_q    <= '0;
            m1Ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrant_q  <= lastGrant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            memAddr_q    <= memAddr_d;
            memDataOut_q <= memDataOut_d;
            memRead_q    <= memRead_d;
            memWrite_q   <= memWrite_d;
            m0Rdata_q    <= m0Rdata_d;
            m0Ack_q      <= m0Ack_d;
            m1Rdata_q    <= m1Rdata_d;
            m1Ack_q      <= m1Ack_d;
        end
    end

    assign bus.mem_address  = memAddr_q;
    assign bus.mem_data_out = memDataOut_q;
    assign bus.mem_read     = memRead_q;
    assign bus.mem_write    = memWrite_q;
    assign bus.m0_rdata     = m0Rdata_q;
    assign bus.m0_ack       = m0Ack_q;
    assign bus.m1_rdata     = m1Rdata_q;
    assign bus.m1_ack       = m1Ack_q;
    assign bus.bus_owner    = owner_q;
    assign bus.busy         = (state_q != IDLE);

    // Strobes are exactly one-hot while in ACCESS and silent elsewhere; acks never overlap.
    assert property (@(posedge clk) disable iff (!n_reset)
        !(memRead_q && memWrite_q));
    assert property (@(posedge clk) disable iff (!n_reset)
        (state_q == ACCESS) |-> (memRead_q ^ memWrite_q));
    assert property (@(posedge clk) disable iff (!n_reset)
        (state_q != ACCESS) |-> !(memRead_q || memWrite_q));
    assert property (@(posedge clk) disable iff (!n_reset)
        !(m0Ack_q && m1Ack_q));
endmodule
